// File: rtl/sat_adder.sv
// Registered two's-complement saturating adder with per-sample clamp flags
// and a sticky-at-max saturation event counter for debug.
module sat_adder #(
    parameter int width     = 8,
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [width-1:0]     a,
    input  logic [width-1:0]     b,
    input  logic                 cnt_clr,
    output logic [width-1:0]     z,
    output logic                 out_valid,
    output logic                 sat_pos,
    output logic                 sat_neg,
    output logic [cnt_width-1:0] sat_count
);

    localparam logic [width-1:0]     MaxVal = {1'b0, {(width-1){1'b1}}};
    localparam logic [width-1:0]     MinVal = {1'b1, {(width-1){1'b0}}};
    localparam logic [cnt_width-1:0] CntMax = {cnt_width{1'b1}};

    logic [width:0]   sum;
    logic             pos_ovf;
    logic             neg_ovf;
    logic [width-1:0] sat_sum;
    logic             sat_hit;

    // Overflow only when both operands share a sign and the result's sign
    // differs; an exact -min result keeps the sign and is therefore legal.
    always_comb begin
        sum     = {a[width-1], a} + {b[width-1], b};
        pos_ovf = ~a[width-1] & ~b[width-1] &  sum[width-1];
        neg_ovf =  a[width-1] &  b[width-1] & ~sum[width-1];
        sat_sum = sum[width-1:0];
        if (pos_ovf) begin
            sat_sum = MaxVal;
        end else if (neg_ovf) begin
            sat_sum = MinVal;
        end
        sat_hit = in_valid & (pos_ovf | neg_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z         <= '0;
            out_valid <= 1'b0;
            sat_pos   <= 1'b0;
            sat_neg   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                z       <= sat_sum;
                sat_pos <= pos_ovf;
                sat_neg <= neg_ovf;
            end else begin
                sat_pos <= 1'b0;
                sat_neg <= 1'b0;
            end
        end
    end

    // Clear wins over a same-cycle increment; the count never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (cnt_clr) begin
            sat_count <= '0;
        end else if (sat_hit && (sat_count != CntMax)) begin
            sat_count <= sat_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_sat_adder.sv
// Directed, table-driven bench for sat_adder: a default 16-bit-counter
// instance and a 2-bit-counter instance share the same stimulus.
module tb_sat_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cnt_clr;
    logic [7:0]  z;
    logic        out_valid;
    logic        sat_pos;
    logic        sat_neg;
    logic [15:0] sat_count;
    logic [7:0]  z2;
    logic        out_valid2;
    logic        sat_pos2;
    logic        sat_neg2;
    logic [1:0]  sat_count2;

    int checks;
    int errors;

    logic [15:0] exp_cnt;
    logic [1:0]  exp_cnt2;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] z;
        logic       pos;
        logic       neg;
    } vec_t;

    vec_t vecs [12];

    sat_adder #(.width(8), .cnt_width(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .cnt_clr(cnt_clr), .z(z), .out_valid(out_valid), .sat_pos(sat_pos),
        .sat_neg(sat_neg), .sat_count(sat_count)
    );

    sat_adder #(.width(8), .cnt_width(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .cnt_clr(cnt_clr), .z(z2), .out_valid(out_valid2), .sat_pos(sat_pos2),
        .sat_neg(sat_neg2), .sat_count(sat_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then land 1 ns past the
    // rising edge so outputs can be sampled; the counter models advance here.
    task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb,
                                 input logic v, input logic clr, input logic sat);
        @(negedge clk);
        a        = va;
        b        = vb;
        in_valid = v;
        cnt_clr  = clr;
        @(posedge clk);
        if (clr) begin
            exp_cnt  = '0;
            exp_cnt2 = '0;
        end else if (v && sat) begin
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 1'b1;
            if (exp_cnt2 != 2'b11) exp_cnt2 = exp_cnt2 + 1'b1;
        end
        #1;
    endtask

    task automatic checkAll(input string tag, input logic [7:0] ez, input logic ev,
                            input logic ep, input logic en);
        checkOutput({tag, " z"}, 32'(z), 32'(ez));
        checkOutput({tag, " out_valid"}, 32'(out_valid), 32'(ev));
        checkOutput({tag, " sat_pos"}, 32'(sat_pos), 32'(ep));
        checkOutput({tag, " sat_neg"}, 32'(sat_neg), 32'(en));
        checkOutput({tag, " sat_count"}, 32'(sat_count), 32'(exp_cnt));
        checkOutput({tag, " sat_count2"}, 32'(sat_count2), 32'(exp_cnt2));
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        exp_cnt  = '0;
        exp_cnt2 = '0;

        vecs[0]  = '{8'h0F, 8'h0F, 8'h1E, 1'b0, 1'b0};
        vecs[1]  = '{8'h00, 8'h80, 8'h80, 1'b0, 1'b0};
        vecs[2]  = '{8'h80, 8'h00, 8'h80, 1'b0, 1'b0};
        vecs[3]  = '{8'h55, 8'h55, 8'h7F, 1'b1, 1'b0};
        vecs[4]  = '{8'h7F, 8'h7F, 8'h7F, 1'b1, 1'b0};
        vecs[5]  = '{8'hC0, 8'hC0, 8'h80, 1'b0, 1'b0};
        vecs[6]  = '{8'hBF, 8'hBF, 8'h80, 1'b0, 1'b1};
        vecs[7]  = '{8'hAA, 8'hAA, 8'h80, 1'b0, 1'b1};
        vecs[8]  = '{8'h7F, 8'h80, 8'hFF, 1'b0, 1'b0};
        vecs[9]  = '{8'h7F, 8'h01, 8'h7F, 1'b1, 1'b0};
        vecs[10] = '{8'h01, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[11] = '{8'h80, 8'hFF, 8'h80, 1'b0, 1'b1};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cnt_clr  = 1'b0;
        #12;
        $display("[TB] reset state");
        checkAll("reset", 8'h00, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] back-to-back vector table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, 1'b1, 1'b0, vecs[i].pos | vecs[i].neg);
            checkAll($sformatf("vec%0d", i), vecs[i].z, 1'b1, vecs[i].pos, vecs[i].neg);
        end

        $display("[TB] idle gap holds z");
        applyStimulus(8'h7F, 8'h7F, 1'b0, 1'b0, 1'b1);
        checkAll("gap1", 8'h80, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0);
        checkAll("gap2", 8'h80, 1'b0, 1'b0, 1'b0);

        $display("[TB] counter clear and small-counter stickiness");
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        checkAll("clr_idle", 8'h80, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h70, 8'h70, 1'b1, 1'b0, 1'b1);
            checkAll($sformatf("stick%0d", i), 8'h7F, 1'b1, 1'b1, 1'b0);
        end
        checkOutput("stick_final_cnt2", 32'(sat_count2), 32'd3);
        checkOutput("stick_final_cnt", 32'(sat_count), 32'd5);
        applyStimulus(8'h90, 8'h90, 1'b1, 1'b1, 1'b1);
        checkAll("clr_with_sat", 8'h80, 1'b1, 1'b0, 1'b1);
        checkOutput("clr_with_sat_cnt", 32'(sat_count), 32'd0);

        $display("[TB] asynchronous reset mid-stream");
        applyStimulus(8'h7F, 8'h7F, 1'b1, 1'b0, 1'b1);
        checkAll("pre_reset", 8'h7F, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt  = '0;
        exp_cnt2 = '0;
        checkAll("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkAll("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h0F, 8'h0F, 1'b1, 1'b0, 1'b0);
        checkAll("post_reset_sample", 8'h1E, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
